axis_frame_rr_arbiter: RTL

Frame-granular round-robin arbiter that shares the write side of an `axis_async_fifo_adapter` instance between `S_COUNT` AXI-Stream sources in the FIFO's `s_clk` domain. It admits a new frame only when the FIFO reports enough free space. It supports pause at frame boundaries and tags each output frame with the granted source index on `m_axis_tid`.

---
 rtl/axis_frame_rr_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_frame_rr_arbiter.sv
// Frame-granular round-robin AXI-Stream arbiter feeding an async FIFO, with free-space admission and pause.
// Optional frame watchdog (timeout abort + drain) enabled by defining AXIS_FRAME_RR_ARBITER_WATCHDOG_EN.
module axis_frame_rr_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 4096,
  parameter int MIN_FREE   = 64,
  parameter int TIMEOUT    = 1024,
  localparam int CL        = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  localparam int AW        = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [CL-1:0]                 m_axis_tid,
  input  logic [AW-1:0]                 fifo_status_depth,
  input  logic                          pause_req,
  output logic                          pause_ack,
  output logic                          timeout_event
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_XFER   = 3'd1,
    ST_ABORT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_PAUSED = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CL-1:0] grant_q, grant_d;
  logic [CL-1:0] last_grant_q, last_grant_d;

  logic [AW-1:0] free_words;
  logic          admit;
  logic [CL-1:0] rr_idx;
  logic          rr_found;
  int            rr_probe;
  logic          grant_valid;
  logic          grant_last;
  logic          xfer_beat;

  assign free_words  = AW'(DEPTH) - fifo_status_depth;
  assign admit       = (free_words >= AW'(MIN_FREE));
  assign grant_valid = s_axis_tvalid[grant_q];
  assign grant_last  = s_axis_tlast[grant_q];
  assign xfer_beat   = (state_q == ST_XFER) && grant_valid && m_axis_tready;

  // Round-robin search starting just after the previous winner, so it ends up lowest priority.
  always_comb begin
    rr_idx   = last_grant_q;
    rr_found = 1'b0;
    rr_probe = 0;
    for (int i = 1; i <= S_COUNT; i++) begin
      rr_probe = (int'(last_grant_q) + i) % S_COUNT;
      if (!rr_found && s_axis_tvalid[rr_probe]) begin
        rr_idx   = CL'(rr_probe);
        rr_found = 1'b1;
      end else begin
        rr_found = rr_found;
      end
    end
  end

`ifdef AXIS_FRAME_RR_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_expire;

  assign wd_expire = !grant_valid && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  // Idle-cycle counter for the granted source; restarts on every transferred beat.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == ST_XFER) begin
      if (xfer_beat) begin
        wd_cnt_d = '0;
      end else if (!grant_valid) begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
    end else begin
      wd_cnt_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CL'(S_COUNT - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic; pause and admission are only considered between frames.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pause_req) begin
          state_d = ST_PAUSED;
        end else if (rr_found && admit) begin
          grant_d      = rr_idx;
          last_grant_d = rr_idx;
          state_d      = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (xfer_beat && grant_last) begin
          state_d = pause_req ? ST_PAUSED : ST_IDLE;
`ifdef AXIS_FRAME_RR_ARBITER_WATCHDOG_EN
        end else if (wd_expire) begin
          state_d = ST_ABORT;
`endif
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_ABORT: begin
`ifdef AXIS_FRAME_RR_ARBITER_WATCHDOG_EN
        state_d = m_axis_tready ? ST_DRAIN : ST_ABORT;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DRAIN: begin
        if (grant_valid && grant_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_PAUSED: begin
        state_d = pause_req ? ST_PAUSED : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: pass-through in XFER, bad-frame marker in ABORT, silent sink in DRAIN.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    m_axis_tid    = '0;
    pause_ack     = 1'b0;
    timeout_event = 1'b0;
    case (state_q)
      ST_XFER: begin
        m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep           = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tuser           = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
        m_axis_tvalid          = grant_valid;
        m_axis_tlast           = grant_last;
        m_axis_tid             = grant_q;
        s_axis_tready[grant_q] = m_axis_tready;
      end
      ST_ABORT: begin
        m_axis_tkeep  = '1;
        m_axis_tuser  = '1;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tid    = grant_q;
`ifdef AXIS_FRAME_RR_ARBITER_WATCHDOG_EN
        timeout_event = m_axis_tready;
`else
        timeout_event = 1'b0;
`endif
      end
      ST_DRAIN: begin
        s_axis_tready[grant_q] = 1'b1;
      end
      ST_PAUSED: begin
        pause_ack = 1'b1;
      end
      default: begin
        pause_ack = 1'b0;
      end
    endcase
  end

endmodule
